btn_gesture_conditioner: RTL and testbench
==========================================

# btn_gesture_conditioner

Conditions the two raw active-low DE0 push-buttons into clean, single-shot button codes for the downstream state-machine stage, which expects a 2-bit code (01, 10, 11) per user gesture and 00 otherwise. Each key is synchronised and debounced. A small gesture FSM then merges everything pressed between the first press and the full release into one code. That code is emitted for exactly one clock when both keys are released.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); legal range ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; the single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- btn_n  in  2  raw keys, active-low (0 = pressed), asynchronous to clk.
- btn_level  out  2  debounced key levels, active-high (1 = pressed).
- btn_code  out  2  gesture code; equals the accumulated code during the emit cycle, 2'b00 in all other cycles.
- btn_valid  out  1  one-cycle strobe, high exactly when btn_code is non-zero.

## Operation
- Per key: 2-FF synchroniser, reset to 1 (released), followed by the debouncer.
- Debouncer:
  - Holds a stable level and a counter.
  - A cycle where sync == stable clears the counter.
  - A mismatch cycle increments the counter.
  - A mismatch cycle with counter == DEBOUNCE_CYCLES-1 flips stable and clears the counter.
  - btn_level = ~stable.
- Gesture FSM, states IDLE / HELD / EMIT, plus a 2-bit accumulator acc:
  - IDLE: if btn_level != 00, then acc <= btn_level and go to HELD. Otherwise stay.
  - HELD: acc <= acc | btn_level. When btn_level == 00, go to EMIT. acc keeps its OR-ed value.
  - EMIT: btn_code = acc, btn_valid = 1, acc <= 00, go to IDLE unconditionally.
- Both keys accepted in the same cycle in IDLE gives acc = 11.
- Pressing A, then also B, then releasing in any order gives code 11.
- Pressing A and releasing it gives code 01. Key 0 maps to bit 0.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches btn_level and produces no gesture.
- A press that is accepted in the EMIT cycle is seen in IDLE on the following cycle. It starts a new gesture one cycle later and is never lost, because btn_level is a level.
- Codes are never queued. Each gesture emits exactly once.

## Timing
- Reset values:
  - synchronisers = 2'b11.
  - stable = 11, so btn_level = 00.
  - counters = 0, acc = 00, state = IDLE.
  - btn_code = 00, btn_valid = 0.
- Outputs are registered; no combinational path from btn_n to any output.
- Latency, raw change to btn_level: the change is visible on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value.
- Latency, btn_level to 00 → strobe: the next edge enters EMIT, and btn_code/btn_valid are high for the following cycle. btn_valid is asserted 1 cycle after btn_level reads 00.
- Reset asserted mid-gesture:
  - All state clears immediately; no code is emitted.
  - A key still held after reset release is re-debounced from the released state and starts a fresh gesture.

## Structure
- Shared package hw_btn_pkg holds:
  - the FSM state localparams (IDLE = 2'd0, HELD = 2'd1, EMIT = 2'd2);
  - the code constants BTN_NONE = 2'b00, BTN_0 = 2'b01, BTN_1 = 2'b10, BTN_BOTH = 2'b11, which the downstream FSM also uses.
- Sub-module btn_debounce (synchroniser + counter + stable level, parameter DEBOUNCE_CYCLES) is instantiated once per key. The top level holds the gesture FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold reset low with btn_n = 00 → btn_level = 00, btn_code = 00, btn_valid = 0 throughout. After release, no strobe while btn_n stays 11.
- Single key: btn_n[0] low for 20 cycles, then high → btn_level[0] rises 6 edges after the press. After release, exactly one cycle of btn_valid = 1, btn_code = 01.
- Chord: btn_n[1] low, btn_n[0] low 8 cycles later, release btn_n[1] first, then btn_n[0] → exactly one strobe with btn_code = 11, emitted after the last release.
- Bounce rejection: toggle btn_n[0] with 3-cycle pulses for 30 cycles → btn_level stays 00, no strobe. A subsequent clean 10-cycle press → one strobe with code 01.
- Back-to-back gestures: btn_n[1] press/release, then btn_n[0] pressed immediately after btn_level returns to 00 → two strobes in order, 10 then 01, none merged.
- Reset mid-gesture: assert reset while btn_n[0] is held and the FSM is in HELD → no strobe. After reset release with the key still held, btn_level[0] re-rises after 6 edges, and a later release gives one 01 strobe.

Source files
------------

// File: rtl/btn_gesture_conditioner_pkg.sv
// Shared button codes and gesture FSM states.
// The downstream state machine uses the same code constants.
package hw_btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        EMIT = 2'd2
    } gst_t;

    localparam logic [1:0] BTN_NONE = 2'b00;
    localparam logic [1:0] BTN_0    = 2'b01;
    localparam logic [1:0] BTN_1    = 2'b10;
    localparam logic [1:0] BTN_BOTH = 2'b11;

endpackage

// File: rtl/btn_gesture_conditioner_debounce.sv
// One key: 2-FF synchroniser feeding a stable-level debouncer.
// level is active-high; the raw key is active-low.
module btn_debounce #(
    parameter int  DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level
);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = ~stable;

endmodule

// File: rtl/btn_gesture_conditioner.sv
// Debounces both keys and merges each press-to-full-release
// gesture into a single one-cycle button code.
module btn_gesture_conditioner
    import hw_btn_pkg::*;
#(
    parameter int  DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_n,
    output logic [1:0] btn_level,
    output logic [1:0] btn_code,
    output logic       btn_valid
);

    gst_t       state;
    logic [1:0] acc;

    for (genvar k = 0; k < 2; k++) begin : g_key
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .btn_n (btn_n[k]),
            .level (btn_level[k])
        );
    end

    // Code is loaded on the edge that enters EMIT so it is
    // registered and visible exactly during the EMIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= BTN_NONE;
            btn_code  <= BTN_NONE;
            btn_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn_level != BTN_NONE) begin
                        acc   <= btn_level;
                        state <= HELD;
                    end
                end
                HELD: begin
                    acc <= acc | btn_level;
                    if (btn_level == BTN_NONE) begin
                        btn_code  <= acc;
                        btn_valid <= (acc != BTN_NONE);
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    acc       <= BTN_NONE;
                    btn_code  <= BTN_NONE;
                    btn_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    acc       <= BTN_NONE;
                    btn_code  <= BTN_NONE;
                    btn_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_gesture_conditioner.sv
// Bench for btn_gesture_conditioner: directed scenarios plus
// random key activity against a run-length/gesture model.
module tb_btn_gesture_conditioner;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] btn_level;
    logic [1:0] btn_code;
    logic       btn_valid;

    int n_cmp = 0;
    int n_bad = 0;

    btn_gesture_conditioner #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_n     (btn_n),
        .btn_level (btn_level),
        .btn_code  (btn_code),
        .btn_valid (btn_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw key delayed by the two sync stages,
    // a per-key run of disagreeing samples, and a gesture mask.
    logic [1:0] d1, d2, m_lvl, m_mask, m_code;
    int         run [2];
    bit         m_in, m_valid;

    int         nstb;
    logic [1:0] last_code;
    logic [1:0] codes [$];

    task automatic model_reset();
        d1 = 2'b11; d2 = 2'b11; m_lvl = 2'b00;
        run[0] = 0; run[1] = 0;
        m_in = 0; m_valid = 0; m_mask = 0; m_code = 0;
    endtask

    task automatic model_edge(input logic [1:0] raw);
        logic [1:0] lv;
        lv = m_lvl;
        if (m_valid) begin
            m_valid = 0; m_code = 0; m_in = 0; m_mask = 0;
        end else if (!m_in) begin
            if (lv != 0) begin m_in = 1; m_mask = lv; end
        end else begin
            m_mask = m_mask | lv;
            if (lv == 0) begin
                m_valid = 1; m_code = m_mask; m_in = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            // pressed level is the inverse of the synced raw key
            if ((~d2[k]) != m_lvl[k]) begin
                run[k]++;
                if (run[k] == DEB) begin
                    m_lvl[k] = ~m_lvl[k];
                    run[k] = 0;
                end
            end else begin
                run[k] = 0;
            end
        end
        d2 = d1;
        d1 = raw;
    endtask

    // Called at a falling edge: drive raw, take one rising edge,
    // then compare on the next falling edge.
    task automatic cyc(input logic [1:0] raw);
        btn_n = raw;
        @(posedge clk);
        if (reset) model_edge(raw);
        @(negedge clk);
        chk("level", btn_level, m_lvl);
        chk("code", btn_code, m_code);
        chk("valid", btn_valid, m_valid);
        if (btn_valid) begin
            nstb++;
            last_code = btn_code;
            codes.push_back(btn_code);
        end
    endtask

    task automatic hold(input logic [1:0] raw, input int n);
        for (int i = 0; i < n; i++) cyc(raw);
    endtask

    task automatic clr();
        nstb = 0; last_code = 0; codes.delete();
    endtask

    initial begin
        int rise, s0, len, guard;
        logic [1:0] r;
        model_reset();
        clr();
        @(negedge clk);

        // reset held with both keys pressed
        reset = 1'b0;
        hold(2'b00, 10);
        chk("rst_level", btn_level, 0);
        chk("rst_code", btn_code, 0);
        chk("rst_valid", btn_valid, 0);
        chk("rst_nstb", nstb, 0);
        reset = 1'b1;
        hold(2'b11, 10);
        chk("idle_nstb", nstb, 0);

        // single key 0
        clr();
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(2'b10);
            if (btn_level[0] && rise == 0) rise = i;
        end
        chk("single_rise", rise, 6);
        hold(2'b11, 12);
        chk("single_nstb", nstb, 1);
        chk("single_code", last_code, 1);

        // chord: key1, then key0, release key1, then key0
        clr();
        hold(2'b01, 8);
        hold(2'b00, 10);
        hold(2'b10, 10);
        s0 = nstb;
        hold(2'b11, 12);
        chk("chord_early", s0, 0);
        chk("chord_nstb", nstb, 1);
        chk("chord_code", last_code, 3);

        // bounce rejection then a clean press
        clr();
        for (int i = 0; i < 5; i++) begin
            hold(2'b10, 3);
            hold(2'b11, 3);
        end
        chk("bounce_nstb", nstb, 0);
        chk("bounce_level", btn_level, 0);
        hold(2'b11, 10);
        hold(2'b10, 10);
        hold(2'b11, 12);
        chk("clean_nstb", nstb, 1);
        chk("clean_code", last_code, 1);

        // back-to-back: key1 gesture, key0 right after level drops
        clr();
        hold(2'b01, 10);
        guard = 0;
        do begin
            cyc(2'b11);
            guard++;
        end while (btn_level != 0 && guard < 20);
        chk("b2b_drop", guard < 20, 1);
        hold(2'b10, 10);
        hold(2'b11, 12);
        chk("b2b_nstb", nstb, 2);
        if (codes.size() == 2) begin
            chk("b2b_first", codes[0], 2);
            chk("b2b_second", codes[1], 1);
        end else begin
            chk("b2b_count", codes.size(), 2);
        end

        // reset while held in a gesture
        clr();
        hold(2'b10, 12);
        reset = 1'b0;
        model_reset();
        hold(2'b10, 4);
        chk("midrst_level", btn_level, 0);
        reset = 1'b1;
        rise = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(2'b10);
            if (btn_level[0] && rise == 0) rise = i;
        end
        chk("midrst_rise", rise, 6);
        chk("midrst_quiet", nstb, 0);
        hold(2'b11, 12);
        chk("midrst_nstb", nstb, 1);
        chk("midrst_code", last_code, 1);

        // random key activity, checked every cycle by the model
        for (int i = 0; i < 300; i++) begin
            r = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            hold(r, len);
        end
        hold(2'b11, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
